// File: rtl/serv_axi_timer_slave.sv
// Single-beat AXI4 responder holding a 64-bit mtime/mtimecmp machine timer and a control
// register; drives the core's timer interrupt. Bursts, IDs and USER fields are ignored.
module serv_axi_timer_slave #(
  parameter int unsigned AW       = 13,
  parameter int unsigned PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_awaddr,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  input  logic          i_wvalid,
  output logic          o_wready,
  output logic [1:0]    o_bresp,
  output logic          o_bvalid,
  input  logic          i_bready,
  input  logic [AW-1:0] i_araddr,
  input  logic          i_arvalid,
  output logic          o_arready,
  output logic [31:0]   o_rdata,
  output logic [1:0]    o_rresp,
  output logic          o_rlast,
  output logic          o_rvalid,
  input  logic          i_rready,
  output logic          o_timer_irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic {WIdle, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  wstate_e        wstate_q, wstate_d;
  rstate_e        rstate_q, rstate_d;
  logic           active_q;
  logic           aw_lat_q, w_lat_q;
  logic [AW-1:2]  awaddr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;
  logic [1:0]     bresp_q, rresp_q;
  logic [31:0]    rdata_q, rd_val;
  logic [63:0]    mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           irq_q;
  logic           aw_hs, w_hs, ar_hs, commit, wr_hit, tick;
  logic           unused_addr_lsbs;

  function automatic logic map_hit(input logic [AW-1:2] a);
    return (a[AW-1:5] == '0) && (a[4:2] <= 3'd4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  assign unused_addr_lsbs = ^{i_araddr[1:0], i_awaddr[1:0]};

  assign aw_hs  = o_awready & i_awvalid;
  assign w_hs   = o_wready & i_wvalid;
  assign ar_hs  = o_arready & i_arvalid;
  assign commit = (wstate_q == WIdle) & aw_lat_q & w_lat_q;
  assign wr_hit = commit & map_hit(awaddr_q);

  // State registers; active_q keeps the readies low until the cycle after reset releases.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wstate_q <= WIdle;
      rstate_q <= RIdle;
      active_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      WIdle:   if (commit) wstate_d = WResp;
      WResp:   if (i_bready) wstate_d = WIdle;
      default: wstate_d = WIdle;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      RIdle:   if (ar_hs) rstate_d = RData;
      RData:   if (i_rready) rstate_d = RIdle;
      default: rstate_d = RIdle;
    endcase
  end

  always_comb begin
    o_awready = active_q && (wstate_q == WIdle) && !aw_lat_q;
    o_wready  = active_q && (wstate_q == WIdle) && !w_lat_q;
    o_bvalid  = (wstate_q == WResp);
    o_arready = active_q && (rstate_q == RIdle);
    o_rvalid  = (rstate_q == RData);
    o_rlast   = o_rvalid;
  end

  assign o_bresp     = bresp_q;
  assign o_rresp     = rresp_q;
  assign o_rdata     = rdata_q;
  assign o_timer_irq = irq_q;

  always_comb begin
    rd_val = '0;
    if (map_hit(i_araddr[AW-1:2])) begin
      case (i_araddr[4:2])
        3'd0:    rd_val = mtime_q[31:0];
        3'd1:    rd_val = mtime_q[63:32];
        3'd2:    rd_val = mtimecmp_q[31:0];
        3'd3:    rd_val = mtimecmp_q[63:32];
        3'd4:    rd_val = {30'd0, ctrl_q};
        default: rd_val = '0;
      endcase
    end
  end

  // Timer next state: increment first, then let committed bytes override it.
  always_comb begin
    tick       = ctrl_q[0] && (presc_q == PW'(PRESCALE - 1));
    presc_d    = presc_q;
    if (ctrl_q[0]) presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    if (wr_hit) begin
      case (awaddr_q[4:2])
        3'd0:    mtime_d[31:0]     = merge(mtime_d[31:0], wdata_q, wstrb_q);
        3'd1:    mtime_d[63:32]    = merge(mtime_d[63:32], wdata_q, wstrb_q);
        3'd2:    mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata_q, wstrb_q);
        3'd3:    mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata_q, wstrb_q);
        3'd4:    if (wstrb_q[0]) ctrl_d = wdata_q[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RespOkay;
      rresp_q    <= RespOkay;
      rdata_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      presc_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_lat_q <= 1'b1;
        awaddr_q <= i_awaddr[AW-1:2];
      end else if (commit) begin
        aw_lat_q <= 1'b0;
      end
      if (w_hs) begin
        w_lat_q <= 1'b1;
        wdata_q <= i_wdata;
        wstrb_q <= i_wstrb;
      end else if (commit) begin
        w_lat_q <= 1'b0;
      end
      if (commit) bresp_q <= wr_hit ? RespOkay : RespSlvErr;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= map_hit(i_araddr[AW-1:2]) ? RespOkay : RespSlvErr;
      end
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      irq_q      <= ctrl_q[1] && (mtime_q >= mtimecmp_q);
    end
  end

endmodule

// File: tb/tb_serv_axi_timer_slave.sv
// Bench for serv_axi_timer_slave: directed scenarios plus random traffic checked against a
// timestamp-based model of the timer registers.
module tb_serv_axi_timer_slave;
  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_awaddr, i_araddr;
  logic          i_awvalid, o_awready, i_wvalid, o_wready, o_bvalid, i_bready;
  logic [31:0]   i_wdata, o_rdata;
  logic [3:0]    i_wstrb;
  logic [1:0]    o_bresp, o_rresp;
  logic          i_arvalid, o_arready, o_rlast, o_rvalid, i_rready, o_timer_irq;

  always #5 clk = ~clk;

  serv_axi_timer_slave #(.AW(AW), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst),
    .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
    .i_rready(i_rready), .o_timer_irq(o_timer_irq)
  );

  int cyc = 0;  // number of rising edges so far == index of the next edge
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Model: mtime is base while frozen, or base + (edges since enable commit - 1) while running.
  logic [63:0] m_base, m_cmp;
  bit          m_run;
  int          m_c;
  logic [1:0]  m_ctrl;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mapped(input logic [AW-1:0] a);
    return int'(a) < 'h14;
  endfunction

  function automatic logic [63:0] mtime_at(input int s);
    if (m_run) return m_base + 64'(s - m_c - 1);
    return m_base;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a, input int s);
    logic [63:0] t;
    t = mtime_at(s);
    if (!mapped(a)) return 32'd0;
    case (int'(a) / 4)
      0:       return t[31:0];
      1:       return t[63:32];
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      default: return {30'd0, m_ctrl};
    endcase
  endfunction

  task automatic model_reset();
    m_base = '0; m_cmp = '1; m_run = 0; m_c = 0; m_ctrl = '0;
  endtask

  // Apply a write committed at edge index c.
  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int c);
    logic [63:0] t;
    if (!mapped(a)) return;
    t = mtime_at(c + 1);
    case (int'(a) / 4)
      0: begin t[31:0] = bmerge(t[31:0], d, s); m_base = t; m_c = c; end
      1: begin t[63:32] = bmerge(t[63:32], d, s); m_base = t; m_c = c; end
      2: m_cmp[31:0] = bmerge(m_cmp[31:0], d, s);
      3: m_cmp[63:32] = bmerge(m_cmp[63:32], d, s);
      default: if (s[0]) begin
        if (m_run && !d[0]) begin m_base = t; m_run = 0; end
        else if (!m_run && d[0]) begin m_run = 1; m_c = c; end
        m_ctrl = d[1:0];
      end
    endcase
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, output logic [1:0] resp,
                           output int commit, output logic irq_bv);
    int aw_start, w_start, n;
    bit aw_done, w_done, aw_hs, w_hs;
    resp = '0; commit = 0; irq_bv = 1'b0;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; n = 0;
    i_awaddr = addr; i_wdata = data; i_wstrb = strb; i_bready = 1'b1;
    while (!(aw_done && w_done) && n < 30) begin
      i_awvalid = !aw_done && n >= aw_start;
      i_wvalid  = !w_done && n >= w_start;
      aw_hs = i_awvalid && o_awready;
      w_hs  = i_wvalid && o_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      n++;
    end
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      vectors++; miscompares++;
      $display("FAIL wr_accept_timeout addr=%h got aw=%0d w=%0d want 1 1", addr, aw_done, w_done);
      i_bready = 1'b0;
      return;
    end
    n = 0;
    while (!o_bvalid && n < 20) begin tick(); n++; end
    if (!o_bvalid) begin
      vectors++; miscompares++;
      $display("FAIL bvalid_timeout addr=%h got bvalid=0 want 1", addr);
      i_bready = 1'b0;
      return;
    end
    commit = cyc - 1; resp = o_bresp; irq_bv = o_timer_irq;
    tick();
    i_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int rdelay, output logic [31:0] data,
                          output logic [1:0] resp, output logic last, output int stamp,
                          output bit held);
    int n;
    held = 1; data = '0; resp = '0; last = 1'b0; stamp = 0;
    i_araddr = addr; i_arvalid = 1'b1; n = 0;
    while (!o_arready && n < 20) begin tick(); n++; end
    if (!o_arready) begin
      i_arvalid = 1'b0; vectors++; miscompares++;
      $display("FAIL ar_timeout addr=%h got arready=0 want 1", addr);
      return;
    end
    stamp = cyc;
    tick();
    i_arvalid = 1'b0; n = 0;
    while (!o_rvalid && n < 20) begin tick(); n++; end
    if (!o_rvalid) begin
      vectors++; miscompares++;
      $display("FAIL rvalid_timeout addr=%h got rvalid=0 want 1", addr);
      return;
    end
    data = o_rdata; resp = o_rresp; last = o_rlast;
    for (int i = 0; i < rdelay; i++) begin
      tick();
      if (!o_rvalid || o_rdata !== data || o_rresp !== resp || o_rlast !== 1'b1) held = 0;
    end
    i_rready = 1'b1;
    tick();
    i_rready = 1'b0;
  endtask

  task automatic setup_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r; int c; logic ib;
    axi_write(a, d, s, 0, r, c, ib);
    model_write(a, d, s, c);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic l; int s; bit h;
    rst = 1'b0; i_awvalid = 1'b1; i_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_timer_irq} !== 6'b0 ||
          {o_bresp, o_rresp, o_rdata} !== 36'd0) begin
        miscompares++;
        $display("FAIL reset_outputs got rdy/vld/irq=%b%b%b%b%b%b resp/data=%h want all 0",
                 o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_timer_irq,
                 {o_bresp, o_rresp, o_rdata});
      end
    end
    i_awvalid = 1'b0; i_arvalid = 1'b0; rst = 1'b1;
    model_reset();
    tick();
    vectors++;
    if ({o_awready, o_wready, o_arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_reset got %b%b%b want 111", o_awready, o_wready, o_arready);
    end
    axi_read(13'h08, 0, d, r, l, s, h);
    vectors++;
    if (d !== 32'hFFFF_FFFF || r !== 2'b00 || l !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mtimecmp_lo got %h/%b/%b want ffffffff/00/1", d, r, l);
    end
  endtask

  task automatic test_write_order();
    logic [31:0] d1, d2; logic [1:0] r; logic l, ib; int c, s1, s2; bit h, extra;
    axi_write(13'h10, 32'd3, 4'h1, 2, r, c, ib);
    model_write(13'h10, 32'd3, 4'h1, c);
    vectors++;
    if (r !== 2'b00) begin
      miscompares++; $display("FAIL w_before_aw_bresp got %b want 00", r);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (o_bvalid !== 1'b0) extra = 1; end
    vectors++;
    if (extra) begin miscompares++; $display("FAIL single_bvalid got extra bvalid want none"); end
    axi_read(13'h10, 0, d1, r, l, s1, h);
    vectors++;
    if (d1 !== 32'd3 || r !== 2'b00) begin
      miscompares++; $display("FAIL ctrl_readback got %h/%b want 00000003/00", d1, r);
    end
    axi_read(13'h00, 0, d1, r, l, s1, h);
    axi_read(13'h00, 1, d2, r, l, s2, h);
    vectors++;
    if (d1 !== exp_rdata(13'h00, s1) || d2 !== exp_rdata(13'h00, s2)) begin
      miscompares++;
      $display("FAIL mtime_running got %h,%h want %h,%h", d1, d2, exp_rdata(13'h00, s1),
               exp_rdata(13'h00, s2));
    end
    vectors++;
    if (d2 - d1 !== 32'(s2 - s1)) begin
      miscompares++; $display("FAIL mtime_rate got delta %0d want %0d", d2 - d1, s2 - s1);
    end
    setup_write(13'h10, 32'd0, 4'hF);
  endtask

  task automatic test_strobes();
    logic [31:0] d; logic [1:0] r; logic l, ib; int c, s; bit h;
    axi_write(13'h0C, 32'hAABB_CCDD, 4'b0101, 0, r, c, ib);
    model_write(13'h0C, 32'hAABB_CCDD, 4'b0101, c);
    axi_read(13'h0C, 0, d, r, l, s, h);
    vectors++;
    if (d !== 32'hFFBB_FFDD || r !== 2'b00) begin
      miscompares++; $display("FAIL byte_strobes got %h/%b want ffbbffdd/00", d, r);
    end
  endtask

  task automatic test_irq();
    logic [1:0] r; logic ib; int c, n;
    setup_write(13'h10, 32'd0, 4'hF);
    setup_write(13'h08, 32'd20, 4'hF);
    setup_write(13'h0C, 32'd0, 4'hF);
    setup_write(13'h00, 32'd0, 4'hF);
    setup_write(13'h04, 32'd0, 4'hF);
    axi_write(13'h10, 32'd3, 4'hF, -1, r, c, ib);
    model_write(13'h10, 32'd3, 4'hF, c);
    vectors++;
    if (o_timer_irq !== 1'b0) begin miscompares++; $display("FAIL irq_early got 1 want 0"); end
    n = 0;
    while (!o_timer_irq && n < 60) begin tick(); n++; end
    // mtime counts from edge c+1, reaches 20 at edge c+20; irq registers on the next edge.
    vectors++;
    if (cyc !== c + 22) begin
      miscompares++; $display("FAIL irq_rise got cycle %0d want %0d", cyc, c + 22);
    end
    axi_write(13'h08, 32'd100, 4'hF, 0, r, c, ib);
    model_write(13'h08, 32'd100, 4'hF, c);
    vectors++;
    if (ib !== 1'b1 || o_timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall got at_commit=%b after=%b want 1 0", ib, o_timer_irq);
    end
    setup_write(13'h10, 32'd0, 4'hF);
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; logic l, ib; int c, s; bit h;
    logic [AW-1:0] a;
    axi_read(13'h14, 5, d, r, l, s, h);
    vectors++;
    if (!h || r !== 2'b10 || d !== 32'd0 || l !== 1'b1) begin
      miscompares++; $display("FAIL unmapped_read_hold got held=%0d %h/%b/%b want 1 0/10/1",
                              h, d, r, l);
    end
    axi_read(13'h20, 0, d, r, l, s, h);
    vectors++;
    if (r !== 2'b10 || d !== 32'd0) begin
      miscompares++; $display("FAIL read_0x20 got %h/%b want 0/10", d, r);
    end
    axi_write(13'h40, $urandom, 4'hF, 1, r, c, ib);
    vectors++;
    if (r !== 2'b10) begin miscompares++; $display("FAIL write_0x40_bresp got %b want 10", r); end
    axi_write(13'h1C, $urandom, 4'hF, -1, r, c, ib);
    vectors++;
    if (r !== 2'b10) begin miscompares++; $display("FAIL write_0x1c_bresp got %b want 10", r); end
    for (int k = 0; k < 5; k++) begin
      a = AW'(4 * k);
      axi_read(a, 0, d, r, l, s, h);
      vectors++;
      if (d !== exp_rdata(a, s) || r !== 2'b00) begin
        miscompares++;
        $display("FAIL regs_untouched addr=%h got %h/%b want %h/00", a, d, r, exp_rdata(a, s));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic [1:0] r; logic l; int s; bit h;
    setup_write(13'h10, 32'd0, 4'hF);
    setup_write(13'h00, 32'hFFFF_FFFF, 4'hF);
    setup_write(13'h04, 32'hFFFF_FFFF, 4'hF);
    setup_write(13'h10, 32'd1, 4'h1);
    for (int k = 1; k >= 0; k--) begin
      axi_read(AW'(4 * k), 0, d, r, l, s, h);
      vectors++;
      if (d !== exp_rdata(AW'(4 * k), s)) begin
        miscompares++;
        $display("FAIL mtime_wrap word=%0d got %h want %h", k, d, exp_rdata(AW'(4 * k), s));
      end
    end
    setup_write(13'h10, 32'd0, 4'hF);
  endtask

  task automatic test_midwrite_reset();
    logic [31:0] d; logic [1:0] r; logic l; int s, n; bit h, bad;
    i_awaddr = 13'h08; i_awvalid = 1'b1; n = 0;
    while (!o_awready && n < 20) begin tick(); n++; end
    tick();
    i_awvalid = 1'b0;
    rst = 1'b0;
    bad = 0;
    tick(); if (o_bvalid !== 1'b0) bad = 1;
    tick(); if (o_bvalid !== 1'b0) bad = 1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin tick(); if (o_bvalid !== 1'b0) bad = 1; end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL midwrite_reset_bvalid got 1 want 0"); end
    i_wdata = 32'h1234_5678; i_wstrb = 4'hF; i_wvalid = 1'b1; n = 0;
    while (!o_wready && n < 20) begin tick(); n++; end
    tick();
    i_wvalid = 1'b0; bad = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (o_bvalid !== 1'b0) bad = 1; end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL aw_dropped_by_reset got bvalid=1 want 0"); end
    axi_read(13'h08, 0, d, r, l, s, h);
    vectors++;
    if (d !== exp_rdata(13'h08, s) || r !== 2'b00) begin
      miscompares++;
      $display("FAIL midwrite_reg got %h/%b want %h/00", d, r, exp_rdata(13'h08, s));
    end
    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    model_reset();
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [31:0] d, wd; logic [3:0] st; logic [1:0] r; logic l, ib, wi;
    int c, s, lead; bit h;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = AW'(4 * $urandom_range(0, 4));
        2:       a = AW'(4 * $urandom_range(5, 7));
        default: a = AW'($urandom) & ~AW'(3);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; st = 4'($urandom); lead = int'($urandom_range(0, 4)) - 2;
        axi_write(a, wd, st, lead, r, c, ib);
        model_write(a, wd, st, c);
        wi = m_ctrl[1] && (mtime_at(c + 1) >= m_cmp);
        vectors++;
        if (r !== (mapped(a) ? 2'b00 : 2'b10) || o_timer_irq !== wi) begin
          miscompares++;
          $display("FAIL rand_write addr=%h got bresp=%b irq=%b want %b %b", a, r, o_timer_irq,
                   mapped(a) ? 2'b00 : 2'b10, wi);
        end
      end else begin
        axi_read(a, int'($urandom_range(0, 3)), d, r, l, s, h);
        vectors++;
        if (d !== exp_rdata(a, s) || r !== (mapped(a) ? 2'b00 : 2'b10) || l !== 1'b1 || !h) begin
          miscompares++;
          $display("FAIL rand_read addr=%h got %h/%b/%b held=%0d want %h/%b/1", a, d, r, l, h,
                   exp_rdata(a, s), mapped(a) ? 2'b00 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cnt, last, gap_bad; bit data_bad;
    logic [31:0] d; logic [1:0] r; logic l; int s; bit h;
    i_awaddr = 13'h0C; i_wdata = 32'h0BAD_F00D; i_wstrb = 4'hF;
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b1;
    cnt = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_bvalid) begin
        if (last >= 0 && i - last != 3) gap_bad++;
        last = i; cnt++;
      end
    end
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    model_write(13'h0C, 32'h0BAD_F00D, 4'hF, 0);
    vectors++;
    if (cnt !== 4 || gap_bad !== 0) begin
      miscompares++; $display("FAIL b2b_write got %0d responses gap_err=%0d want 4 0", cnt, gap_bad);
    end
    i_araddr = 13'h10; i_arvalid = 1'b1; i_rready = 1'b1;
    cnt = 0; data_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_rvalid) begin
        cnt++;
        if (o_rdata !== {30'd0, m_ctrl}) data_bad = 1;
      end
    end
    i_arvalid = 1'b0; i_rready = 1'b0;
    vectors++;
    if (cnt !== 5 || data_bad) begin
      miscompares++; $display("FAIL b2b_read got %0d beats data_err=%0d want 5 0", cnt, data_bad);
    end
    tick();
    axi_read(13'h0C, 0, d, r, l, s, h);
    vectors++;
    if (d !== exp_rdata(13'h0C, s)) begin
      miscompares++; $display("FAIL b2b_readback got %h want %h", d, exp_rdata(13'h0C, s));
    end
  endtask

  initial begin
    rst = 1'b0;
    i_awaddr = '0; i_awvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wvalid = 1'b0;
    i_bready = 1'b0; i_araddr = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    model_reset();
    test_reset();
    test_write_order();
    test_strobes();
    test_irq();
    test_unmapped();
    test_wrap();
    test_midwrite_reset();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
